// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_mp_pkg;

  // This block family resets when rst is low.
  localparam logic RST_ENABLE   = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  // Clear-sweep FSM encodings.
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the register file's write, read and clear-control signals.
// Latency: n/a (wiring only).
// Backpressure: none; the only stall indication is busy, during which writes are dropped.
// Ports: clr/busy (sweep control), we/waddr/wdata/wbe (NWRITE flat write buses),
//        re/raddr/rdata (NREAD flat read buses). master = core side, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  logic                       clr;
  logic                       busy;
  logic [NWRITE-1:0]          we;
  logic [NWRITE*ADDR_W-1:0]   waddr;
  logic [NWRITE*DATA_W-1:0]   wdata;
  logic [NWRITE*DATA_W/8-1:0] wbe;
  logic [NREAD-1:0]           re;
  logic [NREAD*ADDR_W-1:0]    raddr;
  logic [NREAD*DATA_W-1:0]    rdata;

  modport master (
    output clr, we, waddr, wdata, wbe, re, raddr,
    input  busy, rdata
  );

  modport slave (
    input  clr, we, waddr, wdata, wbe, re, raddr,
    output busy, rdata
  );
endinterface

// File: rtl/regfile_mp_bypass_mux.sv
// Per-read-port write-to-read bypass: overlays in-flight write bytes onto the stored word.
// Latency: combinational (0 cycles).
// Backpressure: none.
// Ports: raddr_i (read address), we_i/waddr_i/wdata_i/wbe_i (flat write buses),
//        stored_i (array word at raddr_i), merged_o (byte-merged result).
module regfile_mp_bypass_mux
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NWRITE = 2
) (
  input  logic [ADDR_W-1:0]          raddr_i,
  input  logic [NWRITE-1:0]          we_i,
  input  logic [NWRITE*ADDR_W-1:0]   waddr_i,
  input  logic [NWRITE*DATA_W-1:0]   wdata_i,
  input  logic [NWRITE*DATA_W/8-1:0] wbe_i,
  input  logic [DATA_W-1:0]          stored_i,
  output logic [DATA_W-1:0]          merged_o
);
  localparam int NBYTE = DATA_W / 8;

  logic [DATA_W-1:0] merged;

  // Ascending port order so the highest-indexed matching port overwrites lower ones,
  // mirroring the collision rule the array write uses.
  always_comb begin
    merged = stored_i;
    for (int k = 0; k < NWRITE; k++) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (we_i[k] == WRITE_ENABLE &&
            waddr_i[k*ADDR_W +: ADDR_W] == raddr_i &&
            wbe_i[k*NBYTE + b]) begin
          merged[b*8 +: 8] = wdata_i[k*DATA_W + b*8 +: 8];
        end
      end
    end
  end

  assign merged_o = merged;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports with bypass, NWRITE byte-enabled
//   write ports, entry 0 hardwired zero, one-entry-per-cycle clear sweep.
// Latency: reads 0 cycles; writes land in the array at the next edge (visible same cycle via bypass).
// Backpressure: busy high during reset/sweep; writes are dropped and reads return 0 meanwhile.
// Ports: clk, rst (sync, active-low), bus (regfile_mp_if slave: clr/busy, write and read buses).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NBYTE = DATA_W / 8;

  if (DATA_W % 8 != 0) begin : g_width_check
    $error("regfile_mp: DATA_W must be a multiple of 8");
  end

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------- clear FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------- clear FSM: next state ----------------
  // clr is only looked at in IDLE, so a request mid-sweep cannot restart or extend it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_IDLE: begin
        if (bus.clr) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = RF_IDLE;
        end
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  // ---------------- clear FSM: outputs ----------------
  // Reset is folded in combinationally so busy is high from the moment rst drops.
  always_comb begin
    busy = (rst == RST_ENABLE) || (state_q == RF_CLEAR);
  end

  assign bus.busy = busy;

  // ---------------- array ----------------
  // No per-entry reset; the sweep is the only thing that zeroes storage. Writes are merged
  // per byte in ascending port order so the highest-indexed port wins a collision.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (!busy) begin
      for (int k = 0; k < NWRITE; k++) begin
        if (bus.we[k] == WRITE_ENABLE && bus.waddr[k*ADDR_W +: ADDR_W] != '0) begin
          for (int b = 0; b < NBYTE; b++) begin
            if (bus.wbe[k*NBYTE + b]) begin
              mem_q[bus.waddr[k*ADDR_W +: ADDR_W]][b*8 +: 8] <= bus.wdata[k*DATA_W + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------- read ports ----------------
  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] merged;

    assign ra = bus.raddr[j*ADDR_W +: ADDR_W];

    regfile_mp_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWRITE (NWRITE)
    ) u_bypass (
      .raddr_i  (ra),
      .we_i     (bus.we),
      .waddr_i  (bus.waddr),
      .wdata_i  (bus.wdata),
      .wbe_i    (bus.wbe),
      .stored_i (mem_q[ra]),
      .merged_o (merged)
    );

    // Gating covers reset, sweep, disabled port and the zero register in one place.
    assign bus.rdata[j*DATA_W +: DATA_W] =
      (busy || bus.re[j] != READ_ENABLE || ra == '0) ? '0 : merged;
  end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic idle_inputs();
    bus.clr   = 1'b0;
    bus.we    = '0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.wbe   = '0;
    bus.re    = '0;
    bus.raddr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] be);
    bus.we[p]              = 1'b1;
    bus.waddr[p*AW +: AW]  = a;
    bus.wdata[p*DW +: DW]  = d;
    bus.wbe[p*4 +: 4]      = be;
  endtask

  // Drive a read and queue what it must return once sampled.
  task automatic rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                    input string nm);
    exp_t e;
    bus.re[p]             = 1'b1;
    bus.raddr[p*AW +: AW] = a;
    e.port = p; e.data = exp; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    exp_t e;
    int   cnt;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(0, 5'd7, 32'h0, "rd_during_reset");
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL busy_during_reset: got %b want 1", bus.busy);
    else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (bus.rdata[e.port*DW +: DW] !== e.data)
        $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
      else passed++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cnt++;
      else break;
    end
    checks++;
    if (cnt != 32) $display("FAIL reset_sweep_len: busy cycles %0d want 32", cnt);
    else passed++;
    next_cycle();
    rd(0, 5'd7, 32'h0, "r7_after_sweep");
    rd(1, 5'd7, 32'h0, "r7_after_sweep_p1");
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL busy_after_sweep: got %b want 0", bus.busy);
    else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (bus.rdata[e.port*DW +: DW] !== e.data)
        $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
      else passed++;
    end
  endtask

  task automatic test_basic_rw();
    exp_t e;
    for (int cyc = 0; cyc < 3; cyc++) begin
      next_cycle();
      if (cyc == 0) begin
        wr(0, 5'd5, 32'hDEADBEEF, 4'hF);
        rd(0, 5'd5, 32'hDEADBEEF, "rw_bypass_p0");
        rd(1, 5'd5, 32'hDEADBEEF, "rw_bypass_p1");
      end else if (cyc == 1) begin
        rd(0, 5'd5, 32'hDEADBEEF, "rw_array");
        // port 1 addressed but disabled
        bus.raddr[AW +: AW] = 5'd5;
        e.port = 1; e.data = 32'h0; e.name = "re_gate";
        sb.push_back(e);
      end else begin
        wr(1, 5'd5, 32'h00000011, 4'b0001);
        rd(0, 5'd5, 32'hDEADBE11, "rw_partial_byte");
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (bus.rdata[e.port*DW +: DW] !== e.data)
          $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
        else passed++;
      end
    end
  endtask

  task automatic test_byte_merge();
    exp_t e;
    for (int cyc = 0; cyc < 3; cyc++) begin
      next_cycle();
      if (cyc == 0) begin
        wr(0, 5'd9, 32'h11223344, 4'hF);
      end else if (cyc == 1) begin
        wr(0, 5'd9, 32'hAAAAAAAA, 4'b0011);
        wr(1, 5'd9, 32'hBBBBBBBB, 4'b0110);
        rd(0, 5'd9, 32'h11BBBBAA, "collision_bypass");
      end else begin
        rd(1, 5'd9, 32'h11BBBBAA, "collision_stored");
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (bus.rdata[e.port*DW +: DW] !== e.data)
          $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
        else passed++;
      end
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    for (int cyc = 0; cyc < 2; cyc++) begin
      next_cycle();
      if (cyc == 0) begin
        wr(0, 5'd0, 32'hFFFFFFFF, 4'hF);
        wr(1, 5'd0, 32'hFFFFFFFF, 4'hF);
        rd(0, 5'd0, 32'h0, "r0_same_cycle");
        rd(1, 5'd0, 32'h0, "r0_same_cycle_p1");
      end else begin
        rd(0, 5'd0, 32'h0, "r0_next_cycle");
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (bus.rdata[e.port*DW +: DW] !== e.data)
          $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int cyc = 0; cyc < 3; cyc++) begin
      next_cycle();
      if (cyc == 0) begin
        wr(1, 5'd10, 32'h01020304, 4'hF);
        wr(0, 5'd11, 32'hA5A5A5A5, 4'hF);
        rd(0, 5'd10, 32'h01020304, "b2b_p1_to_rd0");
        rd(1, 5'd11, 32'hA5A5A5A5, "b2b_p0_to_rd1");
      end else if (cyc == 1) begin
        wr(1, 5'd10, 32'hFFFFFFFF, 4'b1000);
        rd(0, 5'd10, 32'hFF020304, "b2b_top_byte");
        rd(1, 5'd11, 32'hA5A5A5A5, "b2b_r11_stored");
      end else begin
        rd(0, 5'd10, 32'hFF020304, "b2b_r10_stored");
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (bus.rdata[e.port*DW +: DW] !== e.data)
          $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
        else passed++;
      end
    end
  endtask

  task automatic test_busy_gating();
    exp_t e;
    int   cnt;
    next_cycle();
    wr(0, 5'd3, 32'h5, 4'hF);
    next_cycle();
    rd(0, 5'd3, 32'h5, "r3_before_clr");
    bus.clr = 1'b1;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (bus.rdata[e.port*DW +: DW] !== e.data)
        $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
      else passed++;
    end
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      next_cycle();
      if (c == 12) bus.clr = 1'b1;
      if (c == 20) begin
        wr(0, 5'd3, 32'h77, 4'hF);
        rd(0, 5'd3, 32'h0, "rd_while_busy");
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (bus.rdata[e.port*DW +: DW] !== e.data)
          $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
        else passed++;
      end
      if (bus.busy !== 1'b1) break;
      cnt++;
    end
    checks++;
    if (cnt != 32) $display("FAIL clr_sweep_len: busy cycles %0d want 32", cnt);
    else passed++;
    next_cycle();
    rd(0, 5'd3, 32'h0, "r3_after_clr");
    rd(1, 5'd9, 32'h0, "r9_after_clr");
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (bus.rdata[e.port*DW +: DW] !== e.data)
        $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    exp_t e;
    int   cnt;
    next_cycle();
    wr(0, 5'd5, 32'hCAFEF00D, 4'hF);
    next_cycle();
    rd(0, 5'd5, 32'hCAFEF00D, "r5_before_sweep");
    bus.clr = 1'b1;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (bus.rdata[e.port*DW +: DW] !== e.data)
        $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
      else passed++;
    end
    repeat (10) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL busy_mid_sweep_reset: got %b want 1", bus.busy);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cnt++;
      else break;
    end
    checks++;
    if (cnt != 32) $display("FAIL restart_sweep_len: busy cycles %0d want 32", cnt);
    else passed++;
    next_cycle();
    rd(0, 5'd5, 32'h0, "r5_after_restart");
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (bus.rdata[e.port*DW +: DW] !== e.data)
        $display("FAIL %s: rdata%0d=%h want %h", e.name, e.port, bus.rdata[e.port*DW +: DW], e.data);
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_basic_rw();
    test_byte_merge();
    test_zero_reg();
    test_back_to_back();
    test_busy_gating();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
